// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state encoding seen by display
// logic, default money width and the price field width.
package vend_pkg;

    localparam int MONEY_W_DEF = 12;
    localparam int PRICE_W     = 8;
    localparam int STATE_W     = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SELECTED = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } vend_state_e;

    function automatic logic is_payout(input vend_state_e s);
        return (s == ST_CHANGE) || (s == ST_REFUND);
    endfunction

endpackage

// File: rtl/vend_timeout.sv
// Inactivity timer for the vending sequencer: counts enabled quiet cycles and
// raises o_expire on the TIMEOUT_CYC-th one. Only built with VEND_TIMEOUT_EN.
module vend_timeout #(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_atLast;

    assign w_atLast = (r_count == LAST);
    assign o_expire = i_enable && !i_clear && w_atLast;

    // Wraps to zero on expiry so a stuck enable cannot fire back-to-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (!i_enable || i_clear || w_atLast) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine transaction sequencer: credit, selection, dispense, change and
// refund. Define VEND_TIMEOUT_EN to add the inactivity auto-refund.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int MONEY_W     = MONEY_W_DEF,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_valid,
    input  logic [PRICE_W-1:0]   sel_price,
    input  logic                 coin_valid,
    input  logic [MONEY_W-1:0]   coin_value,
    input  logic                 buy_req,
    input  logic                 cancel_req,
    input  logic                 dispense_ack,
    output logic                 dispense_req,
    output logic                 change_valid,
    output logic [MONEY_W-1:0]   change_amt,
    output logic [MONEY_W-1:0]   balance,
    output logic [PRICE_W-1:0]   price_q,
    output logic [STATE_W-1:0]   state,
    output logic                 err_short
);

    logic [1:0]         r_rstSync;
    logic               w_run;

    vend_state_e        r_state;
    vend_state_e        w_stateNxt;
    logic [MONEY_W-1:0] r_balance;
    logic [MONEY_W-1:0] w_balanceNxt;
    logic [PRICE_W-1:0] r_price;
    logic [PRICE_W-1:0] w_priceNxt;
    logic               r_errShort;
    logic               w_errShortNxt;

    logic [MONEY_W:0]   w_sum;
    logic               w_coinAccept;
    logic [MONEY_W-1:0] w_balAdd;
    logic [MONEY_W-1:0] w_priceExt;
    logic               w_affordable;
    logic               w_expire;

    // The FSM stays frozen in IDLE until reset release has crossed two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_run = r_rstSync[1];

    // A coin that would overflow the credit register is refused outright.
    assign w_sum        = {1'b0, r_balance} + {1'b0, coin_value};
    assign w_coinAccept = coin_valid && !w_sum[MONEY_W];
    assign w_balAdd     = w_coinAccept ? w_sum[MONEY_W-1:0] : r_balance;
    assign w_priceExt   = MONEY_W'(r_price);
    assign w_affordable = (w_balAdd >= w_priceExt);

`ifdef VEND_TIMEOUT_EN
    logic w_anyPulse;
    logic w_toEnable;

    assign w_anyPulse = sel_valid | coin_valid | buy_req | cancel_req | dispense_ack;
    assign w_toEnable = w_run && ((r_state == ST_SELECTED) ||
                                  ((r_state == ST_IDLE) && (r_balance != '0)));

    vend_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_toEnable),
        .i_clear  (w_anyPulse),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_balance  <= '0;
            r_price    <= '0;
            r_errShort <= 1'b0;
        end else begin
            r_state    <= w_stateNxt;
            r_balance  <= w_balanceNxt;
            r_price    <= w_priceNxt;
            r_errShort <= w_errShortNxt;
        end
    end

    // Event priority is cancel, then buy, then select; a coin arriving with a
    // cancel is folded into the refund via w_balAdd.
    always_comb begin
        w_stateNxt    = r_state;
        w_balanceNxt  = r_balance;
        w_priceNxt    = r_price;
        w_errShortNxt = 1'b0;
        if (w_run) begin
            case (r_state)
                ST_IDLE: begin
                    w_balanceNxt = w_balAdd;
                    if (cancel_req || w_expire) begin
                        w_stateNxt = ST_REFUND;
                    end else if (sel_valid) begin
                        w_priceNxt = sel_price;
                        w_stateNxt = ST_SELECTED;
                    end
                end
                ST_SELECTED: begin
                    w_balanceNxt = w_balAdd;
                    if (cancel_req || w_expire) begin
                        w_stateNxt = ST_REFUND;
                    end else if (buy_req) begin
                        if (w_affordable) begin
                            w_stateNxt = ST_DISPENSE;
                        end else begin
                            w_errShortNxt = 1'b1;
                        end
                    end else if (sel_valid) begin
                        w_priceNxt = sel_price;
                    end
                end
                ST_DISPENSE: begin
                    if (dispense_ack) begin
                        w_stateNxt = ST_CHANGE;
                    end
                end
                default: begin
                    w_stateNxt   = ST_IDLE;
                    w_balanceNxt = '0;
                    w_priceNxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        change_amt = '0;
        case (r_state)
            ST_CHANGE: change_amt = r_balance - w_priceExt;
            ST_REFUND: change_amt = r_balance;
            default:   change_amt = '0;
        endcase
    end

    assign dispense_req = (r_state == ST_DISPENSE);
    assign change_valid = is_payout(r_state);
    assign balance      = r_balance;
    assign price_q      = r_price;
    assign state        = r_state;
    assign err_short    = r_errShort;

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter MONEY_W, default 12, width of all money quantities (price units).
REQ-002 Parameter TIMEOUT_CYC, default 5_000_000, idle cycles before auto-refund (used only with VEND_TIMEOUT_EN).
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 sel_valid  in  1  one-cycle pulse: goods selection present.
REQ-006 sel_price  in  8  price of selected goods, sampled on sel_valid.
REQ-007 coin_valid  in  1  one-cycle pulse: coin inserted.
REQ-008 coin_value  in  MONEY_W  coin value, sampled on coin_valid.
REQ-009 buy_req  in  1  one-cycle purchase request.
REQ-010 cancel_req  in  1  one-cycle cancel/refund request.
REQ-011 dispense_ack  in  1  dispenser completion handshake.
REQ-012 dispense_req  out  1  held high in DISPENSE until dispense_ack.
REQ-013 change_valid  out  1  one-cycle pulse; change_amt valid.
REQ-014 change_amt  out  MONEY_W  money returned (change or refund).
REQ-015 balance  out  MONEY_W  current accumulated credit.
REQ-016 price_q  out  8  latched price of current selection, 0 if none.
REQ-017 state  out  3  encoded FSM state for display logic.
REQ-018 err_short  out  1  one-cycle pulse: buy_req with balance < price_q.

Function
REQ-019 FSM states: IDLE=0, SELECTED=1, DISPENSE=2, CHANGE=3, REFUND=4.
REQ-020 IDLE: coin adds to balance; sel_valid latches price_q and goes SELECTED next cycle.
REQ-021 SELECTED: coins add; sel_valid re-latches price_q; buy_req with balance >= price_q -> DISPENSE, else err_short pulse, stay.
REQ-022 buy_req in IDLE is ignored, no err_short.
REQ-023 Balance add saturates at 2^MONEY_W-1; saturated coin is not accepted (no wrap).
REQ-024 DISPENSE: dispense_req=1; coins, sel_valid, buy_req, cancel_req ignored; on dispense_ack -> CHANGE next cycle.
REQ-025 CHANGE: exactly one cycle; change_valid=1, change_amt = balance - price_q; next cycle IDLE, balance=0, price_q=0.
REQ-026 Change pulse is emitted even when change is 0.
REQ-027 cancel_req in IDLE/SELECTED -> REFUND; REFUND one cycle: change_valid=1, change_amt=balance; then IDLE, balance=0, price_q=0.
REQ-028 Simultaneous events same cycle, priority: cancel_req > buy_req > sel_valid; coin_valid is always added unless state is DISPENSE/CHANGE/REFUND or target is REFUND (then coin is included in refund).
REQ-029 buy_req plus same-cycle coin_valid: comparison uses balance + coin.
REQ-030 change_amt is 0 whenever change_valid is 0.

Reset
REQ-031 On rst low: state=IDLE, balance=0, price_q=0, all pulses/dispense_req=0, change_amt=0, timeout counter=0.
REQ-032 Reset mid-DISPENSE abandons transaction; no change pulse emitted.
REQ-033 Reset release is synchronised; FSM leaves IDLE no earlier than second clock after deassert.

Configuration
REQ-034 Macro VEND_TIMEOUT_EN: when defined, counter clears on any input pulse; reaching TIMEOUT_CYC in SELECTED, or IDLE with balance > 0, forces REFUND.
REQ-035 Without VEND_TIMEOUT_EN: no counter logic; machine waits indefinitely; TIMEOUT_CYC unused.

Structure
REQ-036 Shared package vend_pkg holds state encoding enum, MONEY_W default, and state constants used by display logic.
REQ-037 One sub-module vend_timeout (counter, clear, expire pulse), instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-038 Coins 50,50 with select price 80, buy -> DISPENSE; ack after 3 cycles -> change_valid, change_amt=20, balance 0.
REQ-039 Select price 100, coin 50, buy -> err_short pulse, stays SELECTED, balance 50.
REQ-040 Coin 30, cancel plus coin 20 same cycle -> REFUND, change_amt=50.
REQ-041 Balance 4090, coin 10 -> coin rejected, balance stays 4090.
REQ-042 Assert rst during DISPENSE -> all outputs 0, IDLE, no change pulse.
REQ-043 VEND_TIMEOUT_EN, TIMEOUT_CYC=100: coin 20, idle 100 cycles -> REFUND, change_amt=20.
